ras_checkpointed: RTL and testbench
===================================

# ras_checkpointed

Parametrised return-address stack with speculative checkpoint/restore. It sits between fetch and the branch predictor, and supersedes the fixed-depth RAS. It predicts return targets for call/return pairs. On every fetched branch it saves the stack pointer, count and top entry, and on a branch misprediction it restores that state, so wrong-path calls and returns do not corrupt the prediction stack.

## Interface
Parameters:
- DEPTH, 8: stack entries; power of two, ≥2.
- ADDR_W, 32: return-address width.
- CKPT_DEPTH, 4: maximum unretired fetched branches; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  call fetched: push new_addr.
- pop  in  1  return fetched: pop top.
- new_addr  in  ADDR_W  return address to push.
- branch_fetched  in  1  take a checkpoint this cycle.
- branch_retired  in  1  oldest checkpoint is no longer needed.
- mispredict  in  1  restore from the oldest checkpoint.
- addr  out  ADDR_W  current top-of-stack prediction.
- valid  out  1  stack non-empty (count != 0).
- ckpt_full  out  1  CKPT_DEPTH checkpoints outstanding; fetch must stall branches.
- ckpt_empty  out  1  no checkpoints outstanding.

## Operation
- Storage is a circular array stack[DEPTH], a tos pointer of log2(DEPTH) bits, and count of 0..DEPTH. addr = stack[tos].
- Push only: tos ← tos+1 (wraps), stack[tos+1] ← new_addr, count ← min(count+1, DEPTH). At overflow the oldest entry is silently overwritten.
- Pop only with count>0: tos ← tos−1 (wraps), count−1.
- Pop only with count=0: no state change. addr is stale, valid=0.
- Push and pop together: stack[tos] ← new_addr. tos and count are unchanged.
- Checkpoint entry = {tos, count, top}. It is taken from the post-push/pop state of the same cycle, so the branch's own call/return is preserved.
- Checkpoints are kept in a FIFO of CKPT_DEPTH entries.
  - branch_retired pops the oldest checkpoint.
  - branch_fetched and branch_retired in the same cycle: push and pop both occur; occupancy is unchanged.
  - branch_fetched while ckpt_full (without a retire that cycle) is a protocol error: the checkpoint is dropped and a simulation assertion fires.
  - branch_retired while ckpt_empty is ignored, and an assertion fires.
- mispredict:
  - tos ← oldest.tos, count ← oldest.count, stack[oldest.tos] ← oldest.top. This repairs a top entry overwritten on the wrong path.
  - The checkpoint FIFO is emptied; the mispredicted branch counts as retired.
  - push, pop, branch_fetched and branch_retired in the same cycle are ignored.
  - If the FIFO is empty, mispredict is ignored and an assertion fires.
- Entries below top that were overwritten on the wrong path are not repaired. This is an accepted accuracy loss.

## Timing
- Reset values: tos=0, count=0, all stack entries 0, checkpoint FIFO empty. Outputs: addr=0, valid=0, ckpt_full=0, ckpt_empty=1. Reset is asynchronous and takes effect immediately mid-operation, including during a pending restore.
- addr, valid, ckpt_full and ckpt_empty are combinational from registered state. There is no input-to-output combinational path.
- push/pop update is visible on addr the cycle after the edge.
- A restore is visible on addr the cycle after mispredict.
- A checkpoint taken in cycle N is usable by a mispredict in cycle N+1.
- ckpt_full rises the cycle after the CKPT_DEPTH-th fetch and falls the cycle after a retire or mispredict.

## Structure
- Shared package (cva5_types): ras_ckpt_t packed struct {tos, count, top}, with widths derived from DEPTH/ADDR_W; also the self_ras/fetch_ras port structs widened to ADDR_W.
- Sub-module ras_checkpoint_queue: a CKPT_DEPTH×ras_ckpt_t circular FIFO.
  - Ports: push, pop, clear.
  - Outputs: oldest entry, full, empty.
  - Read and write pointers are one bit wider than log2(CKPT_DEPTH) to distinguish full from empty.
- Top level holds the stack array, the tos/count logic and the restore muxing.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 → addr 0x300, valid=1; three pops → addr 0x200, 0x100, then valid=0. A fourth pop leaves count=0.
- DEPTH=8: push 0x10..0x90 (9 entries) → count saturates at 8; eight pops return 0x90..0x20; the 9th pop gives valid=0.
- Push 0xA0, then a cycle with push 0xB0 + pop together → addr 0xB0, count unchanged at 1.
- Push 0x40, branch_fetched; wrong path: pop, push 0x99, push 0x98; mispredict → next cycle addr 0x40, count 1, ckpt_empty=1.
- Four branch_fetched with no retires → ckpt_full=1. Fetch and retire in the same cycle → stays full. One retire alone → ckpt_full=0 the next cycle.
- Assert rst asynchronously mid-restore with 3 checkpoints outstanding → immediately addr=0, valid=0, ckpt_empty=1.

Source files
------------

// File: rtl/ras_checkpointed_pkg.sv
// Shared types for the checkpointed return-address stack.
//
// Contents:
//   RAS_DEPTH / RAS_ADDR_W  default stack depth and return-address width
//   ras_ckpt_t              checkpoint record {tos, count, top} at the default widths
//   self_ras_t              fetch-side request into the RAS (push/pop/new_addr)
//   fetch_ras_t             prediction returned to fetch (addr/valid)
//   ras_ckpt_width()        checkpoint record width for any DEPTH/ADDR_W pair
package cva5_types;

    localparam int RAS_DEPTH  = 8;
    localparam int RAS_ADDR_W = 32;

    typedef struct packed {
        logic [$clog2(RAS_DEPTH)-1:0] tos;
        logic [$clog2(RAS_DEPTH):0]   count;
        logic [RAS_ADDR_W-1:0]        top;
    } ras_ckpt_t;

    typedef struct packed {
        logic                  push;
        logic                  pop;
        logic [RAS_ADDR_W-1:0] new_addr;
    } self_ras_t;

    typedef struct packed {
        logic [RAS_ADDR_W-1:0] addr;
        logic                  valid;
    } fetch_ras_t;

    // tos needs log2(depth) bits; count spans 0..depth so it needs one more.
    function automatic int ras_ckpt_width(input int depth, input int addr_w);
        return 2 * $clog2(depth) + 1 + addr_w;
    endfunction

endpackage

// File: rtl/ras_checkpoint_queue.sv
// Circular FIFO holding RAS checkpoints, oldest entry always visible.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        append push_data (dropped when full unless a pop happens too)
//   pop         discard the oldest entry (ignored when empty)
//   clear       empty the FIFO; takes priority over push/pop
//   push_data   entry to append
//   oldest      current oldest entry (meaningless when empty)
//   full/empty  occupancy flags
module ras_checkpoint_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] oldest,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign oldest = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign do_pop  = pop && !empty && !clear;
    // A push into a full FIFO is accepted only when the oldest slot is freed
    // in the same cycle; it then lands in the slot being vacated.
    assign do_push = push && (!full || do_pop) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

`ifndef SYNTHESIS
    a_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !clear && full && !pop))
        else $error("ras_checkpoint_queue: checkpoint dropped, queue full");
    a_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && !clear && empty))
        else $error("ras_checkpoint_queue: retire with no checkpoint outstanding");
`endif

endmodule

// File: rtl/ras_checkpointed.sv
// Return-address stack with speculative checkpoint/restore.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, new_addr  call fetched: push return address
//   pop             return fetched: pop top of stack
//   branch_fetched  snapshot {tos, count, top} after this cycle's push/pop
//   branch_retired  discard the oldest snapshot
//   mispredict      restore from the oldest snapshot and drop all snapshots
//   addr, valid     top-of-stack prediction and non-empty flag
//   ckpt_full       snapshot queue full: fetch must stall branches
//   ckpt_empty      no snapshots outstanding
module ras_checkpointed
    import cva5_types::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 32,
    parameter int CKPT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] new_addr,
    input  logic              branch_fetched,
    input  logic              branch_retired,
    input  logic              mispredict,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              ckpt_full,
    output logic              ckpt_empty
);
    localparam int TOS_W  = $clog2(DEPTH);
    localparam int CNT_W  = TOS_W + 1;
    localparam int CKPT_W = ras_ckpt_width(DEPTH, ADDR_W);

    typedef struct packed {
        logic [TOS_W-1:0]  tos;
        logic [CNT_W-1:0]  count;
        logic [ADDR_W-1:0] top;
    } ckpt_t;

    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [TOS_W-1:0]  tos_q, tos_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              wr_en;
    logic [TOS_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_data;
    logic [ADDR_W-1:0] top_d;
    logic              restore;
    ckpt_t             ckpt_in, ckpt_oldest;
    logic [CKPT_W-1:0] oldest_bits;

    assign addr  = stack_q[tos_q];
    assign valid = (count_q != '0);

    // A mispredict with nothing to restore from is treated as absent.
    assign restore     = mispredict && !ckpt_empty;
    assign ckpt_oldest = ckpt_t'(oldest_bits);

    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tos_q;
        wr_data = new_addr;
        if (restore) begin
            // Rewriting the saved top repairs a wrong-path overwrite of it.
            tos_d   = ckpt_oldest.tos;
            count_d = ckpt_oldest.count;
            wr_en   = 1'b1;
            wr_idx  = ckpt_oldest.tos;
            wr_data = ckpt_oldest.top;
        end else if (push && pop) begin
            wr_en = 1'b1;
        end else if (push) begin
            tos_d   = tos_q + 1'b1;
            wr_en   = 1'b1;
            wr_idx  = tos_q + 1'b1;
            count_d = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + 1'b1;
        end else if (pop && valid) begin
            tos_d   = tos_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    // Snapshot reflects this cycle's push/pop, including a same-cycle write
    // to the new top that is not yet in the array.
    assign top_d   = (wr_en && (wr_idx == tos_d)) ? wr_data : stack_q[tos_d];
    assign ckpt_in = '{tos: tos_d, count: count_d, top: top_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_idx == TOS_W'(i))) stack_q[i] <= wr_data;
            end
        end
    end

    ras_checkpoint_queue #(
        .DEPTH (CKPT_DEPTH),
        .WIDTH (CKPT_W)
    ) u_ckpt_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (branch_fetched && !restore),
        .pop       (branch_retired && !restore),
        .clear     (restore),
        .push_data (ckpt_in),
        .oldest    (oldest_bits),
        .full      (ckpt_full),
        .empty     (ckpt_empty)
    );

`ifndef SYNTHESIS
    a_mispredict_empty: assert property (@(posedge clk) disable iff (rst)
        !(mispredict && ckpt_empty))
        else $error("ras_checkpointed: mispredict with no checkpoint outstanding");
`endif

endmodule

// File: tb/tb_ras_checkpointed.sv
module tb_ras_checkpointed;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0, pop = 1'b0;
    logic [31:0] new_addr = '0;
    logic        branch_fetched = 1'b0, branch_retired = 1'b0, mispredict = 1'b0;
    logic [31:0] addr;
    logic        valid, ckpt_full, ckpt_empty;

    int checks = 0;
    int fails  = 0;

    ras_checkpointed #(.DEPTH(8), .ADDR_W(32), .CKPT_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .pop            (pop),
        .new_addr       (new_addr),
        .branch_fetched (branch_fetched),
        .branch_retired (branch_retired),
        .mispredict     (mispredict),
        .addr           (addr),
        .valid          (valid),
        .ckpt_full      (ckpt_full),
        .ckpt_empty     (ckpt_empty)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 0; pop = 0; new_addr = '0;
        branch_fetched = 0; branch_retired = 0; mispredict = 0;
    endtask

    task automatic do_push(input logic [31:0] a);
        push = 1; new_addr = a; tick(); idle();
    endtask

    task automatic do_pop();
        pop = 1; tick(); idle();
    endtask

    task automatic test_reset();
        rst = 1; idle(); tick(); tick();
        rst = 0; tick();
        checks++; if (addr !== 32'h0) begin fails++; $display("FAIL reset_addr actual=%h expected=%h", addr, 32'h0); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid actual=%b expected=0", valid); end
        checks++; if (ckpt_full !== 1'b0) begin fails++; $display("FAIL reset_full actual=%b expected=0", ckpt_full); end
        checks++; if (ckpt_empty !== 1'b1) begin fails++; $display("FAIL reset_empty actual=%b expected=1", ckpt_empty); end
        $display("reset: addr=%h valid=%b full=%b empty=%b", addr, valid, ckpt_full, ckpt_empty);
    endtask

    task automatic test_push_pop();
        do_push(32'h100); do_push(32'h200); do_push(32'h300);
        checks++; if (addr !== 32'h300) begin fails++; $display("FAIL pp_top actual=%h expected=%h", addr, 32'h300); end
        checks++; if (valid !== 1'b1) begin fails++; $display("FAIL pp_valid actual=%b expected=1", valid); end
        do_pop();
        checks++; if (addr !== 32'h200) begin fails++; $display("FAIL pp_pop1 actual=%h expected=%h", addr, 32'h200); end
        do_pop();
        checks++; if (addr !== 32'h100 || valid !== 1'b1) begin fails++; $display("FAIL pp_pop2 actual=%h/%b expected=%h/1", addr, valid, 32'h100); end
        do_pop();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL pp_pop3_valid actual=%b expected=0", valid); end
        do_pop();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL pp_underflow_valid actual=%b expected=0", valid); end
        // Count must still be 0: one push then one pop empties it again.
        do_push(32'h55);
        checks++; if (addr !== 32'h55 || valid !== 1'b1) begin fails++; $display("FAIL pp_after_underflow actual=%h/%b expected=%h/1", addr, valid, 32'h55); end
        do_pop();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL pp_count_zero actual=%b expected=0", valid); end
        $display("push_pop: addr=%h valid=%b", addr, valid);
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 9; k++) do_push(32'(k * 16));
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (addr !== 32'(32'h90 - 16 * k) || valid !== 1'b1) begin
                fails++; $display("FAIL ovf_pop%0d actual=%h/%b expected=%h/1", k, addr, valid, 32'(32'h90 - 16 * k));
            end
            do_pop();
        end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ovf_saturated_valid actual=%b expected=0", valid); end
        do_pop();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ovf_extra_pop actual=%b expected=0", valid); end
        $display("overflow: valid=%b after 8 pops", valid);
    endtask

    task automatic test_push_pop_same();
        do_push(32'hA0);
        checks++; if (addr !== 32'hA0) begin fails++; $display("FAIL same_first actual=%h expected=%h", addr, 32'hA0); end
        push = 1; pop = 1; new_addr = 32'hB0; tick(); idle();
        checks++; if (addr !== 32'hB0 || valid !== 1'b1) begin fails++; $display("FAIL same_replace actual=%h/%b expected=%h/1", addr, valid, 32'hB0); end
        do_pop();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL same_count1 actual=%b expected=0", valid); end
        $display("push_pop_same: valid=%b", valid);
    endtask

    task automatic test_mispredict();
        do_push(32'h40);
        branch_fetched = 1; tick(); idle();
        checks++; if (ckpt_empty !== 1'b0) begin fails++; $display("FAIL mp_ckpt_taken actual=%b expected=0", ckpt_empty); end
        do_pop(); do_push(32'h99); do_push(32'h98);
        checks++; if (addr !== 32'h98) begin fails++; $display("FAIL mp_wrong_path actual=%h expected=%h", addr, 32'h98); end
        // The push alongside the mispredict must be ignored.
        mispredict = 1; push = 1; new_addr = 32'h77; tick(); idle();
        checks++; if (addr !== 32'h40) begin fails++; $display("FAIL mp_restore_addr actual=%h expected=%h", addr, 32'h40); end
        checks++; if (valid !== 1'b1) begin fails++; $display("FAIL mp_restore_valid actual=%b expected=1", valid); end
        checks++; if (ckpt_empty !== 1'b1) begin fails++; $display("FAIL mp_fifo_cleared actual=%b expected=1", ckpt_empty); end
        do_pop();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL mp_restore_count actual=%b expected=0", valid); end
        $display("mispredict: restored addr 0x40, fifo empty");
    endtask

    task automatic test_ckpt_full();
        for (int k = 0; k < 3; k++) begin branch_fetched = 1; tick(); idle(); end
        checks++; if (ckpt_full !== 1'b0) begin fails++; $display("FAIL full_at3 actual=%b expected=0", ckpt_full); end
        branch_fetched = 1; tick(); idle();
        checks++; if (ckpt_full !== 1'b1) begin fails++; $display("FAIL full_at4 actual=%b expected=1", ckpt_full); end
        branch_fetched = 1; branch_retired = 1; tick(); idle();
        checks++; if (ckpt_full !== 1'b1) begin fails++; $display("FAIL full_fetch_retire actual=%b expected=1", ckpt_full); end
        branch_retired = 1; tick(); idle();
        checks++; if (ckpt_full !== 1'b0 || ckpt_empty !== 1'b0) begin fails++; $display("FAIL full_after_retire actual=%b/%b expected=0/0", ckpt_full, ckpt_empty); end
        $display("ckpt_full: full=%b empty=%b with 3 outstanding", ckpt_full, ckpt_empty);
    endtask

    task automatic test_async_reset();
        do_push(32'h123);
        checks++; if (addr !== 32'h123) begin fails++; $display("FAIL ar_pre actual=%h expected=%h", addr, 32'h123); end
        mispredict = 1;
        #2 rst = 1;
        #1;
        checks++; if (addr !== 32'h0 || valid !== 1'b0) begin fails++; $display("FAIL ar_immediate actual=%h/%b expected=0/0", addr, valid); end
        checks++; if (ckpt_empty !== 1'b1 || ckpt_full !== 1'b0) begin fails++; $display("FAIL ar_fifo actual=empty %b full %b expected=1/0", ckpt_empty, ckpt_full); end
        tick(); idle(); rst = 0; tick();
        checks++; if (addr !== 32'h0 || valid !== 1'b0 || ckpt_empty !== 1'b1) begin fails++; $display("FAIL ar_released actual=%h/%b/%b expected=0/0/1", addr, valid, ckpt_empty); end
        $display("async_reset: addr=%h valid=%b empty=%b", addr, valid, ckpt_empty);
    endtask

    task automatic test_oldest();
        push = 1; new_addr = 32'h11; branch_fetched = 1; tick(); idle();
        push = 1; new_addr = 32'h22; branch_fetched = 1; tick(); idle();
        do_pop(); do_pop();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL old_emptied actual=%b expected=0", valid); end
        branch_retired = 1; tick(); idle();
        mispredict = 1; tick(); idle();
        checks++; if (addr !== 32'h22 || valid !== 1'b1) begin fails++; $display("FAIL old_restore actual=%h/%b expected=%h/1", addr, valid, 32'h22); end
        do_pop();
        checks++; if (addr !== 32'h11 || valid !== 1'b1) begin fails++; $display("FAIL old_below actual=%h/%b expected=%h/1", addr, valid, 32'h11); end
        do_pop();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL old_count2 actual=%b expected=0", valid); end
        $display("oldest: second checkpoint restored after retire");
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_push_pop_same();
        test_mispredict();
        test_ckpt_full();
        test_async_reset();
        test_oldest();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
